// File: rtl/ctrl_pkg.sv
// Shared types and constants for the multi-cycle MIPS-subset sequencer:
// FSM states, opcode/funct encodings, ALU operation codes and the select bundle.
package ctrl_pkg;

    localparam int unsigned DATA_W   = 32;
    localparam int unsigned OP_W     = 6;
    localparam int unsigned FUNCT_W  = 6;
    localparam int unsigned ALUCTR_W = 3;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_IF   = 3'd1,
        ST_ID   = 3'd2,
        ST_EX   = 3'd3,
        ST_MEM  = 3'd4,
        ST_WB   = 3'd5,
        ST_HALT = 3'd6
    } state_t;

    localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
    localparam logic [OP_W-1:0] OP_ORI   = 6'b001101;
    localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
    localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OP_W-1:0] OP_J     = 6'b000010;

    localparam logic [FUNCT_W-1:0] FN_ADD  = 6'b100000;
    localparam logic [FUNCT_W-1:0] FN_ADDU = 6'b100001;
    localparam logic [FUNCT_W-1:0] FN_SUB  = 6'b100010;
    localparam logic [FUNCT_W-1:0] FN_SUBU = 6'b100011;
    localparam logic [FUNCT_W-1:0] FN_AND  = 6'b100100;
    localparam logic [FUNCT_W-1:0] FN_OR   = 6'b100101;
    localparam logic [FUNCT_W-1:0] FN_SLT  = 6'b101010;

    localparam logic [ALUCTR_W-1:0] ALU_ADDU = 3'b000;
    localparam logic [ALUCTR_W-1:0] ALU_ADD  = 3'b001;
    localparam logic [ALUCTR_W-1:0] ALU_OR   = 3'b010;
    localparam logic [ALUCTR_W-1:0] ALU_AND  = 3'b011;
    localparam logic [ALUCTR_W-1:0] ALU_SUBU = 3'b100;
    localparam logic [ALUCTR_W-1:0] ALU_SUB  = 3'b101;
    localparam logic [ALUCTR_W-1:0] ALU_SLT  = 3'b110;

    // Datapath select bundle produced by decode
    typedef struct packed {
        logic                reg_dst;
        logic                alu_src;
        logic                ext_op;
        logic                mem_to_reg;
        logic [ALUCTR_W-1:0] alu_ctr;
    } sel_t;

    localparam sel_t SEL_NONE = '0;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational decode of the latched instruction into datapath selects,
// an instruction class, an illegal flag and a signed-overflow-op flag.
module ctrl_decode
    import ctrl_pkg::*;
(
    input  logic [31:0] ir,
    output logic        reg_dst,
    output logic        alu_src,
    output logic        ext_op,
    output logic        mem_to_reg,
    output logic [2:0]  alu_ctr,
    output logic        is_alu,
    output logic        is_lw,
    output logic        is_sw,
    output logic        is_beq,
    output logic        is_j,
    output logic        illegal,
    output logic        signed_op
);

    logic [OP_W-1:0]    op;
    logic [FUNCT_W-1:0] funct;
    sel_t               sel;

    assign op    = ir[31:26];
    assign funct = ir[5:0];

    // Register and immediate fields only matter to the datapath
    logic unused_fields;
    assign unused_fields = ^ir[25:6];

    always_comb begin
        sel       = SEL_NONE;
        is_alu    = 1'b0;
        is_lw     = 1'b0;
        is_sw     = 1'b0;
        is_beq    = 1'b0;
        is_j      = 1'b0;
        illegal   = 1'b0;
        signed_op = 1'b0;

        case (op)
            OP_RTYPE: begin
                sel.reg_dst = 1'b1;
                is_alu      = 1'b1;
                case (funct)
                    FN_ADD: begin
                        sel.alu_ctr = ALU_ADD;
                        signed_op   = 1'b1;
                    end
                    FN_ADDU: sel.alu_ctr = ALU_ADDU;
                    FN_SUB: begin
                        sel.alu_ctr = ALU_SUB;
                        signed_op   = 1'b1;
                    end
                    FN_SUBU: sel.alu_ctr = ALU_SUBU;
                    FN_AND:  sel.alu_ctr = ALU_AND;
                    FN_OR:   sel.alu_ctr = ALU_OR;
                    FN_SLT:  sel.alu_ctr = ALU_SLT;
                    default: illegal     = 1'b1;
                endcase
            end
            OP_ADDI: begin
                sel.alu_src = 1'b1;
                sel.ext_op  = 1'b1;
                sel.alu_ctr = ALU_ADD;
                is_alu      = 1'b1;
                signed_op   = 1'b1;
            end
            OP_ORI: begin
                sel.alu_src = 1'b1;
                sel.alu_ctr = ALU_OR;
                is_alu      = 1'b1;
            end
            OP_LW: begin
                sel.alu_src    = 1'b1;
                sel.ext_op     = 1'b1;
                sel.mem_to_reg = 1'b1;
                sel.alu_ctr    = ALU_ADDU;
                is_lw          = 1'b1;
            end
            OP_SW: begin
                sel.alu_src = 1'b1;
                sel.ext_op  = 1'b1;
                sel.alu_ctr = ALU_ADDU;
                is_sw       = 1'b1;
            end
            OP_BEQ: begin
                sel.ext_op  = 1'b1;
                sel.alu_ctr = ALU_SUBU;
                is_beq      = 1'b1;
            end
            OP_J:    is_j    = 1'b1;
            default: illegal = 1'b1;
        endcase

        // An illegal instruction must not leak any select or class
        if (illegal) begin
            sel       = SEL_NONE;
            is_alu    = 1'b0;
            signed_op = 1'b0;
        end
    end

    assign reg_dst    = sel.reg_dst;
    assign alu_src    = sel.alu_src;
    assign ext_op     = sel.ext_op;
    assign mem_to_reg = sel.mem_to_reg;
    assign alu_ctr    = sel.alu_ctr;

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle IF/ID/EX/MEM/WB sequencer for the MIPS-subset datapath with
// run/step control, illegal-opcode halt, sticky overflow and a retire counter.
module multicycle_ctrl
    import ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        run,
    input  logic        step,
    input  logic [31:0] instruction,
    input  logic        Zero,
    input  logic        Overflow,
    output logic        pc_en,
    output logic        RegWr,
    output logic        MemWr,
    output logic        Branch,
    output logic        Jump,
    output logic        ExtOp,
    output logic        AluSrc,
    output logic        MemtoReg,
    output logic        RegDst,
    output logic [2:0]  Aluctr,
    output logic        busy,
    output logic        done,
    output logic        halted,
    output logic        ovf,
    output logic [31:0] retired
);

    state_t              state;
    state_t              next_state;
    logic [DATA_W-1:0]   ir;
    logic                complete;
    logic                sel_en;

    logic                dec_reg_dst;
    logic                dec_alu_src;
    logic                dec_ext_op;
    logic                dec_mem_to_reg;
    logic [ALUCTR_W-1:0] dec_alu_ctr;
    logic                is_alu;
    logic                is_lw;
    logic                is_sw;
    logic                is_beq;
    logic                is_j;
    logic                illegal;
    logic                signed_op;

    // Zero is combined with Branch inside the datapath's PC mux
    logic unused_zero;
    assign unused_zero = Zero;

    ctrl_decode u_decode (
        .ir         (ir),
        .reg_dst    (dec_reg_dst),
        .alu_src    (dec_alu_src),
        .ext_op     (dec_ext_op),
        .mem_to_reg (dec_mem_to_reg),
        .alu_ctr    (dec_alu_ctr),
        .is_alu     (is_alu),
        .is_lw      (is_lw),
        .is_sw      (is_sw),
        .is_beq     (is_beq),
        .is_j       (is_j),
        .illegal    (illegal),
        .signed_op  (signed_op)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ir <= '0;
        end else if (state == ST_IF) begin
            ir <= instruction;
        end
    end

    // Retire count advances on the edge closing each completion cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            retired <= '0;
        end else if (done) begin
            retired <= retired + DATA_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf <= 1'b0;
        end else if ((state == ST_WB) && signed_op && Overflow) begin
            ovf <= 1'b1;
        end
    end

    always_comb begin
        next_state = state;
        complete   = 1'b0;
        sel_en     = 1'b0;
        pc_en      = 1'b0;
        RegWr      = 1'b0;
        MemWr      = 1'b0;
        Branch     = 1'b0;
        Jump       = 1'b0;
        ExtOp      = 1'b0;
        AluSrc     = 1'b0;
        MemtoReg   = 1'b0;
        RegDst     = 1'b0;
        Aluctr     = ALU_ADDU;
        busy       = 1'b0;
        done       = 1'b0;
        halted     = 1'b0;

        case (state)
            ST_IDLE: begin
                if (run || step) begin
                    next_state = ST_IF;
                end
            end
            ST_IF: begin
                busy       = 1'b1;
                next_state = ST_ID;
            end
            ST_ID: begin
                busy       = 1'b1;
                sel_en     = 1'b1;
                next_state = illegal ? ST_HALT : ST_EX;
            end
            ST_EX: begin
                busy   = 1'b1;
                sel_en = 1'b1;
                if (is_alu) begin
                    next_state = ST_WB;
                end else if (is_lw || is_sw) begin
                    next_state = ST_MEM;
                end else begin
                    complete = 1'b1;
                    Branch   = is_beq;
                    Jump     = is_j;
                end
            end
            ST_MEM: begin
                busy   = 1'b1;
                sel_en = 1'b1;
                if (is_sw) begin
                    MemWr    = 1'b1;
                    complete = 1'b1;
                end else begin
                    next_state = ST_WB;
                end
            end
            ST_WB: begin
                busy     = 1'b1;
                sel_en   = 1'b1;
                // Overflowing signed ops leave the register file untouched
                RegWr    = !(signed_op && Overflow);
                complete = 1'b1;
            end
            ST_HALT: begin
                halted = 1'b1;
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase

        if (complete) begin
            done       = 1'b1;
            pc_en      = 1'b1;
            next_state = run ? ST_IF : ST_IDLE;
        end

        if (sel_en) begin
            RegDst   = dec_reg_dst;
            AluSrc   = dec_alu_src;
            ExtOp    = dec_ext_op;
            MemtoReg = dec_mem_to_reg;
            Aluctr   = dec_alu_ctr;
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: the driver pushes per-instruction
// expectations from a mnemonic table, a negedge monitor checks each completion.
module tb_multicycle_ctrl;

    logic        clk;
    logic        rst;
    logic        run;
    logic        step;
    logic [31:0] instruction;
    logic        Zero;
    logic        Overflow;
    logic        pc_en;
    logic        RegWr;
    logic        MemWr;
    logic        Branch;
    logic        Jump;
    logic        ExtOp;
    logic        AluSrc;
    logic        MemtoReg;
    logic        RegDst;
    logic [2:0]  Aluctr;
    logic        busy;
    logic        done;
    logic        halted;
    logic        ovf;
    logic [31:0] retired;

    multicycle_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .run         (run),
        .step        (step),
        .instruction (instruction),
        .Zero        (Zero),
        .Overflow    (Overflow),
        .pc_en       (pc_en),
        .RegWr       (RegWr),
        .MemWr       (MemWr),
        .Branch      (Branch),
        .Jump        (Jump),
        .ExtOp       (ExtOp),
        .AluSrc      (AluSrc),
        .MemtoReg    (MemtoReg),
        .RegDst      (RegDst),
        .Aluctr      (Aluctr),
        .busy        (busy),
        .done        (done),
        .halted      (halted),
        .ovf         (ovf),
        .retired     (retired)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [31:0] instr;
        int          lat;
        logic        regwr;
        logic        memwr;
        logic        branch;
        logic        jump;
        logic [6:0]  sel;
        logic        sets_ovf;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    logic [6:0] cur_sel;
    assign cur_sel = {RegDst, AluSrc, ExtOp, MemtoReg, Aluctr};

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
    endtask

    // Mnemonic table: 0 add 1 addu 2 sub 3 subu 4 and 5 or 6 slt 7 addi 8 ori 9 lw 10 sw 11 beq 12 j
    function automatic exp_t make(input int m, input logic ovf_in);
        exp_t        e;
        logic [4:0]  rs = 5'($urandom);
        logic [4:0]  rt = 5'($urandom);
        logic [4:0]  rd = 5'($urandom);
        logic [4:0]  sh = 5'($urandom);
        logic [15:0] imm = 16'($urandom);
        logic [25:0] tgt = 26'($urandom);
        logic [2:0]  al = 3'b000;
        logic rdst = 0, src = 0, ext = 0, m2r = 0, wr = 0, mw = 0, br = 0, jp = 0, sgn = 0;
        int lat = 4;
        case (m)
            0:  begin e.instr = {6'h00, rs, rt, rd, sh, 6'b100000}; al = 3'b001; rdst = 1; wr = 1; sgn = 1; end
            1:  begin e.instr = {6'h00, rs, rt, rd, sh, 6'b100001}; al = 3'b000; rdst = 1; wr = 1; end
            2:  begin e.instr = {6'h00, rs, rt, rd, sh, 6'b100010}; al = 3'b101; rdst = 1; wr = 1; sgn = 1; end
            3:  begin e.instr = {6'h00, rs, rt, rd, sh, 6'b100011}; al = 3'b100; rdst = 1; wr = 1; end
            4:  begin e.instr = {6'h00, rs, rt, rd, sh, 6'b100100}; al = 3'b011; rdst = 1; wr = 1; end
            5:  begin e.instr = {6'h00, rs, rt, rd, sh, 6'b100101}; al = 3'b010; rdst = 1; wr = 1; end
            6:  begin e.instr = {6'h00, rs, rt, rd, sh, 6'b101010}; al = 3'b110; rdst = 1; wr = 1; end
            7:  begin e.instr = {6'b001000, rs, rt, imm}; al = 3'b001; src = 1; ext = 1; wr = 1; sgn = 1; end
            8:  begin e.instr = {6'b001101, rs, rt, imm}; al = 3'b010; src = 1; wr = 1; end
            9:  begin e.instr = {6'b100011, rs, rt, imm}; al = 3'b000; src = 1; ext = 1; m2r = 1; wr = 1; lat = 5; end
            10: begin e.instr = {6'b101011, rs, rt, imm}; al = 3'b000; src = 1; ext = 1; mw = 1; end
            11: begin e.instr = {6'b000100, rs, rt, imm}; al = 3'b100; ext = 1; br = 1; lat = 3; end
            default: begin e.instr = {6'b000010, tgt}; jp = 1; lat = 3; end
        endcase
        e.lat      = lat;
        e.regwr    = wr & ~(sgn & ovf_in);
        e.memwr    = mw;
        e.branch   = br;
        e.jump     = jp;
        e.sel      = {rdst, src, ext, m2r, al};
        e.sets_ovf = sgn & ovf_in;
        return e;
    endfunction

    // Monitor: samples at negedge and pops one expectation per done pulse
    initial begin
        int          cyc;
        bit          early;
        bit          sel_bad;
        bit          pend;
        logic [31:0] ret_m;
        logic        ovf_m;
        exp_t        e;
        cyc = 0; early = 0; sel_bad = 0; pend = 0; ret_m = '0; ovf_m = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                cyc = 0; early = 0; sel_bad = 0; pend = 0; ret_m = '0; ovf_m = 1'b0;
                continue;
            end
            if (pend) begin
                check("retired_after_done", retired, ret_m);
                check("ovf_after_done", ovf, ovf_m);
                pend = 0;
            end
            if (busy) begin
                cyc++;
                if (!done && (RegWr || MemWr || Branch || Jump || pc_en)) early = 1;
                if (cyc == 1) begin
                    if (cur_sel != 7'd0) sel_bad = 1;
                end else if (sb.size() > 0 && cur_sel != sb[0].sel) begin
                    sel_bad = 1;
                end
                if (done) begin
                    if (sb.size() == 0) begin
                        n_checks++;
                        $display("FAIL unexpected_done: done with empty scoreboard at t=%0t, required no done", $time);
                    end else begin
                        e = sb.pop_front();
                        check("latency", 64'(cyc), 64'(e.lat));
                        check("done_strobes", {RegWr, MemWr, Branch, Jump, pc_en},
                              {e.regwr, e.memwr, e.branch, e.jump, 1'b1});
                        check("done_selects", cur_sel, e.sel);
                        check("early_strobe", early, 1'b0);
                        check("select_phase", sel_bad, 1'b0);
                        check("retired_at_done", retired, ret_m);
                        ret_m = ret_m + 32'd1;
                        ovf_m = ovf_m | e.sets_ovf;
                        pend  = 1;
                    end
                    cyc = 0; early = 0; sel_bad = 0;
                end
            end else begin
                check("idle_outputs", {pc_en, RegWr, MemWr, Branch, Jump, done, cur_sel}, 64'd0);
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
        Zero = 1'($urandom);
    endtask

    // Issue one instruction; returns at the completion cycle
    task automatic issue(input exp_t e, input logic ovf_in, input bit use_step, input bit extra_step);
        int k;
        if (use_step) begin
            run = 1'b0;
            tick();
            instruction = e.instr;
            Overflow    = ovf_in;
            sb.push_back(e);
            step = 1'b1;
            tick();
            step = 1'b0;
        end else begin
            instruction = e.instr;
            run = 1'b1;
            sb.push_back(e);
            tick();
            Overflow = ovf_in;
        end
        k = 0;
        while (!done && k < 16) begin
            tick();
            k++;
            step = extra_step && (k == 1);
        end
        step = 1'b0;
        if (!done) begin
            n_checks++;
            $display("FAIL completion_timeout: no done for instr %08h within 16 cycles", e.instr);
        end
    endtask

    initial begin
        exp_t        e;
        logic [31:0] ret_save;
        rst = 1'b1; run = 1'b0; step = 1'b0; instruction = '0; Zero = 1'b0; Overflow = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("reset_outputs", {pc_en, RegWr, MemWr, Branch, Jump, cur_sel, busy, done, halted, ovf}, 64'd0);
        check("reset_retired", retired, 32'd0);
        rst = 1'b0;
        tick();
        check("post_reset_idle", {busy, halted, ovf}, 3'b000);

        // Directed sequence under run
        e = make(0, 1'b0);  e.instr = 32'h00221820; issue(e, 1'b0, 0, 0);
        e = make(9, 1'b0);  e.instr = 32'h8C220004; issue(e, 1'b0, 0, 0);
        e = make(10, 1'b0); e.instr = 32'hAC220008; issue(e, 1'b0, 0, 0);
        e = make(11, 1'b0); e.instr = 32'h10220003; issue(e, 1'b0, 0, 0);
        e = make(12, 1'b0); e.instr = 32'h08000010; issue(e, 1'b0, 0, 0);
        // addi overflowing in WB, single-stepped with a stray step while busy
        e = make(7, 1'b1);  e.instr = 32'h20220005; issue(e, 1'b1, 1, 1);
        run = 1'b0;
        tick(); tick();
        check("step_returns_idle", busy, 1'b0);
        check("ovf_sticky", ovf, 1'b1);
        check("retired_count_directed", retired, 32'd6);

        // Randomized mix of run and step issue
        for (int i = 0; i < 150; i++) begin
            int   m;
            logic o;
            bit   s;
            bit   x;
            m = int'($urandom_range(0, 12));
            o = 1'($urandom_range(0, 1));
            s = ($urandom_range(0, 2) == 0);
            x = s && ($urandom_range(0, 1) == 1);
            e = make(m, o);
            issue(e, o, s, x);
        end
        run = 1'b0;
        tick(); tick();
        check("random_drained_idle", busy, 1'b0);
        check("scoreboard_drained", 64'(sb.size()), 64'd0);
        check("retired_count_random", retired, 32'd156);

        // Illegal opcode halts after ID and ignores run/step
        ret_save = retired;
        instruction = 32'hFC000000;
        run = 1'b1;
        tick();
        tick();
        check("illegal_id_selects", cur_sel, 7'd0);
        tick();
        check("halt_entered", {halted, busy}, 2'b10);
        repeat (4) begin
            step = ~step;
            tick();
        end
        step = 1'b0;
        check("halt_held", {halted, busy, RegWr, MemWr, pc_en}, 5'b10000);
        check("halt_no_retire", retired, ret_save);
        run = 1'b0;

        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        check("halt_cleared_by_rst", {halted, ovf}, 2'b00);
        check("retired_cleared", retired, 32'd0);

        // Reset asserted during WB of a stepped add
        e = make(0, 1'b0);
        instruction = e.instr;
        Overflow = 1'b0;
        sb.push_back(e);
        step = 1'b1;
        tick();
        step = 1'b0;
        tick(); tick(); tick();
        check("wb_regwr_before_rst", {RegWr, done}, 2'b11);
        rst = 1'b1;
        #1;
        check("regwr_async_drop", {RegWr, done, pc_en, busy}, 4'b0000);
        check("rst_mid_wb_retired", retired, 32'd0);
        sb.delete();
        tick();
        rst = 1'b0;
        tick(); tick();
        check("after_rst_not_retired", retired, 32'd0);
        check("after_rst_idle", busy, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
